rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
- Sequences the single register-file write port (PW/RW/LE) between two sources: the pipeline writeback stage and the long-latency unit (load-return / mult-div result).
- Writeback has priority and no backpressure; long-latency results are buffered in a small FIFO and drained into idle write-port cycles.
- A 32-entry scoreboard tracks issued-but-unwritten long-latency destinations and produces the decode-stage stall.

Parameters:
- FIFO_DEPTH, 4: long-latency result buffer entries (power of 2, >=2).
- STARVE_MAX, 8: consecutive blocked cycles before the starvation guard fires (used only with the optional feature).

Ports:
- Clk  in  1  clock; all state updates on posedge.
- clr_n  in  1  asynchronous, active-low reset.
- wb_valid  in  1  writeback write request, always accepted.
- wb_rd  in  5  writeback destination.
- wb_data  in  32  writeback value.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  FIFO can accept; equals !full.
- lu_rd  in  5  long-latency destination.
- lu_data  in  32  long-latency value.
- iss_valid  in  1  long-latency op issued this cycle.
- iss_rd  in  5  its destination.
- rs_a, rs_b  in  5 each  decode-stage source registers.
- stall  out  1  decode must hold.
- rf_le  out  1  register file write enable (registered).
- rf_rw  out  5  register file write address (registered).
- rf_pw  out  32  register file write data (registered).
- pend_mask  out  32  scoreboard bits.
- fifo_level  out  3  FIFO occupancy, 0..FIFO_DEPTH.
- sb_err  out  1  sticky protocol-error flag.
- wb_hold  out  1  starvation-guard request. Tied 0 without the macro.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - rf_le=0, rf_rw=0, rf_pw=0.
  - FIFO flushed; fifo_level=0, lu_ready=1.
  - pend_mask=0, sb_err=0, wb_hold=0, starvation counter=0.
  - Reset mid-operation discards all buffered entries; they are not written.
- Handshake: an LU entry is enqueued when lu_valid && lu_ready. lu_ready is registered-state-derived and never combinationally dependent on lu_valid.
- Each cycle, the write-port selector picks exactly one source:
  - wb_valid && wb_rd!=0 -> source WB.
  - else FIFO non-empty -> source LU (head popped).
  - else none.
- The selected source's rd/data are registered onto rf_rw/rf_pw with rf_le=1 at the next edge. Latency: WB 1 cycle; LU minimum 2 cycles (enqueue edge, then drain edge).
- Writes to rd=0: a WB write to r0 is dropped (rf_le stays 0, slot treated as idle for LU drain). An LU entry with rd=0 is popped without asserting rf_le.
- Simultaneous enqueue and pop: fifo_level unchanged. Full with no pop -> lu_ready=0. Enqueue while full never happens, because the handshake forbids it.
- Pointers wrap modulo FIFO_DEPTH; level is tracked separately so full and empty are unambiguous.
- Scoreboard:
  - iss_valid && iss_rd!=0 sets pend[iss_rd].
  - An LU write actually driven (rf_le from LU source) clears pend[rf_rw] at the same edge it is registered.
  - Set and clear of the same index in one cycle -> set wins.
  - iss_valid to an index already pending and not being cleared -> sb_err set (sticky until reset).
- stall = (rs_a!=0 && pend[rs_a]) || (rs_b!=0 && pend[rs_b]). Combinational from pend_mask and rs inputs.
- A WB write to a pending rd is legal and does not clear pend.

Optional Feature:
- Macro: RF_ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit counter increments each cycle the FIFO is non-empty and WB wins the port; it resets on any LU drain.
  - At count==STARVE_MAX-1, wb_hold=1 for one cycle. The next cycle, the FIFO head has priority over WB and the counter clears.
  - Upstream must keep wb_valid=0 in that cycle; if wb_valid=1 then, the WB write is still performed the following cycle (one-entry skid register) and sb_err is set.
- Undefined: strict WB priority; wb_hold tied 0; no counter or skid logic.

Decomposition:
- Package rf_arb_pkg:
  - Constants ADDR_W=5, DATA_W=32, NUM_REGS=32.
  - Enum wr_src_e {SRC_NONE, SRC_WB, SRC_LU}.
  - Struct rf_wr_t {rd, data}.
- Sub-module rf_wr_fifo: synchronous FIFO of rf_wr_t with push/pop/full/empty/level and async active-low clear.

Test Plan:
- Reset with FIFO holding 3 entries and pend_mask=0x0000_0104 -> all outputs 0, lu_ready=1, fifo_level=0, nothing written afterward.
- WB-only: wb_valid, rd=7, data=0xDEADBEEF at cycle N -> rf_le=1, rf_rw=7, rf_pw=0xDEADBEEF during N+1.
- LU with idle WB: iss rd=9, then lu rd=9, data=0x1234 accepted at cycle N -> during N+1 stall=1 for rs_a=9; rf_le with rw=9 during N+2; pend[9] clears; stall=0 at N+2.
- Contention: wb_valid held 6 cycles while 4 LU results arrive -> lu_ready=0 after the 4th; LU writes emerge in arrival order in the 4 cycles after WB stops, each exactly once.
- r0 and error cases: wb rd=0 -> no rf_le. Issue rd=5 twice without a return -> sb_err=1. Issue and LU clear of rd=5 in the same cycle -> pend[5] stays 1.
- RF_ARB_STARVE_GUARD_EN, STARVE_MAX=8, FIFO non-empty, continuous wb_valid -> wb_hold pulses in the 8th blocked cycle; the LU entry drains the next cycle; wb_valid asserted during the hold -> sb_err=1 and the WB write lands one cycle late.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_arb_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    // Which requester owns the write port in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WB,
        SRC_LU
    } wr_src_e;

    // One register-file write: destination plus value.
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Synchronous FIFO of pending long-latency register writes.
// Occupancy is tracked in its own counter so full and empty never alias,
// and the pointers simply wrap modulo DEPTH (DEPTH is a power of two).
module rf_wr_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   Clk,
    input  logic                   clr_n,
    input  logic                   push_i,
    input  rf_wr_t                 wdata_i,
    input  logic                   pop_i,
    output rf_wr_t                 rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    rf_wr_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [LVL_W-1:0]   level_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // An overfull push or an empty pop is simply ignored.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage write.
    // NOTE: the data array has no reset; an entry is only observable once
    // level_q says it is valid, so clearing it would buy nothing.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy update; reset flushes every buffered entry.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter.
// Writeback owns the port whenever it has a real (non-r0) write; long-latency
// results wait in a small FIFO and drain into idle port cycles. A 32-bit
// scoreboard of issued-but-unwritten destinations drives the decode stall.
// Optional build macro RF_ARB_STARVE_GUARD_EN adds a starvation guard that
// periodically gives the FIFO head priority over writeback.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
`ifdef RF_ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_MAX = 8
`endif
) (
    input  logic        Clk,
    input  logic        clr_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  rs_a,
    input  logic [4:0]  rs_b,
    output logic        stall,
    output logic        rf_le,
    output logic [4:0]  rf_rw,
    output logic [31:0] rf_pw,
    output logic [31:0] pend_mask,
    output logic [2:0]  fifo_level,
    output logic        sb_err,
    output logic        wb_hold
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // FIFO interface
    rf_wr_t                 wb_in;
    rf_wr_t                 lu_in;
    rf_wr_t                 fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [LVL_W-1:0]       fifo_lvl;
    logic                   fifo_pop;

    // Port selection
    wr_src_e                src;
    rf_wr_t                 wr;

    // Registered write port and scoreboard
    logic                   rf_le_q,  rf_le_d;
    logic [ADDR_W-1:0]      rf_rw_q,  rf_rw_d;
    logic [DATA_W-1:0]      rf_pw_q,  rf_pw_d;
    logic [NUM_REGS-1:0]    pend_q,   pend_d;
    logic                   sb_err_q, sb_err_d;
    logic [NUM_REGS-1:0]    set_mask;
    logic [NUM_REGS-1:0]    clr_mask;
    logic                   iss_err;
    logic                   wb_req;

`ifdef RF_ARB_STARVE_GUARD_EN
    logic [3:0]             starve_q,     starve_d;
    logic                   lu_prio_q,    lu_prio_d;
    logic                   skid_valid_q, skid_valid_d;
    rf_wr_t                 skid_q,       skid_d;
    logic                   guard_err;
    logic                   hold_now;
`endif

    assign wb_in  = '{rd: wb_rd, data: wb_data};
    assign lu_in  = '{rd: lu_rd, data: lu_data};
    assign wb_req = wb_valid && (wb_rd != '0);

    // lu_ready comes from registered occupancy only, never from lu_valid.
    assign lu_ready   = !fifo_full;
    assign fifo_level = 3'(fifo_lvl);

    rf_wr_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .clr_n   (clr_n),
        .push_i  (lu_valid && lu_ready),
        .wdata_i (lu_in),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_lvl)
    );

    // Pick the single source that owns the write port this cycle.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        src      = SRC_NONE;
        fifo_pop = 1'b0;
        wr       = '0;
`ifdef RF_ARB_STARVE_GUARD_EN
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        guard_err    = 1'b0;
        if (lu_prio_q && !fifo_empty) begin
            // Guard cycle: FIFO head wins; a writeback arriving now is a
            // protocol error and is parked in the skid register.
            src      = SRC_LU;
            fifo_pop = 1'b1;
            wr       = fifo_head;
            if (wb_req) begin
                guard_err = 1'b1;
                if (!skid_valid_q) begin
                    skid_valid_d = 1'b1;
                    skid_d       = wb_in;
                end
            end
        end else if (skid_valid_q) begin
            // Parked writeback goes first; a new one takes its place so
            // writeback order is preserved.
            src          = SRC_WB;
            wr           = skid_q;
            skid_valid_d = wb_req;
            skid_d       = wb_in;
        end else if (wb_req) begin
            src = SRC_WB;
            wr  = wb_in;
        end else if (!fifo_empty) begin
            src      = SRC_LU;
            fifo_pop = 1'b1;
            wr       = fifo_head;
        end
`else
        if (wb_req) begin
            src = SRC_WB;
            wr  = wb_in;
        end else if (!fifo_empty) begin
            // Idle port (including a dropped r0 writeback): drain one entry.
            src      = SRC_LU;
            fifo_pop = 1'b1;
            wr       = fifo_head;
        end
`endif
    end

    // Next write-port value and scoreboard update; set beats clear.
    always_comb begin
        rf_le_d  = (src != SRC_NONE) && (wr.rd != '0);
        rf_rw_d  = rf_le_d ? wr.rd   : rf_rw_q;
        rf_pw_d  = rf_le_d ? wr.data : rf_pw_q;

        clr_mask = '0;
        if (src == SRC_LU && wr.rd != '0) begin
            clr_mask[wr.rd] = 1'b1;
        end
        set_mask = '0;
        if (iss_valid && iss_rd != '0) begin
            set_mask[iss_rd] = 1'b1;
        end

        iss_err  = iss_valid && (iss_rd != '0) && pend_q[iss_rd] && !clr_mask[iss_rd];
        pend_d   = (pend_q & ~clr_mask) | set_mask;
        sb_err_d = sb_err_q | iss_err;
`ifdef RF_ARB_STARVE_GUARD_EN
        sb_err_d = sb_err_d | guard_err;
`endif
    end

    // Write-port, scoreboard and error-flag registers.
    always_ff @(posedge Clk or negedge clr_n) begin
        if (!clr_n) begin
            rf_le_q  <= 1'b0;
            rf_rw_q  <= '0;
            rf_pw_q  <= '0;
            pend_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            rf_le_q  <= rf_le_d;
            rf_rw_q  <= rf_rw_d;
            rf_pw_q  <= rf_pw_d;
            pend_q   <= pend_d;
            sb_err_q <= sb_err_d;
        end
    end

`ifdef RF_ARB_STARVE_GUARD_EN
    assign hold_now = (starve_q == 4'(STARVE_MAX - 1));

    // Count cycles the FIFO waits behind writeback; any drain restarts it.
    always_comb begin
        starve_d  = starve_q;
        if (src == SRC_LU) begin
            starve_d = '0;
        end else if (src == SRC_WB && !fifo_empty && starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end
        lu_prio_d = hold_now && (src == SRC_WB);
    end

    // Starvation-guard state.
    always_ff @(posedge Clk or negedge clr_n) begin
        if (!clr_n) begin
            starve_q     <= '0;
            lu_prio_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            starve_q     <= starve_d;
            lu_prio_q    <= lu_prio_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    assign wb_hold = hold_now;
`else
    assign wb_hold = 1'b0;
`endif

    assign stall     = ((rs_a != '0) && pend_q[rs_a]) || ((rs_b != '0) && pend_q[rs_b]);
    assign rf_le     = rf_le_q;
    assign rf_rw     = rf_rw_q;
    assign rf_pw     = rf_pw_q;
    assign pend_mask = pend_q;
    assign sb_err    = sb_err_q;

endmodule
